pc_sequencer: RTL

//  Program-counter sequencer for the CSE141 core: owns the PC register, steps it each cycle
//  and resolves taken branches via the absolute-target jump LUT (8-bit index -> D-bit target).

---
 rtl/pc_seq_pkg.sv | 12 +
 rtl/pc_ret_stack.sv | 53 +++++
 rtl/pc_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    localparam int LUT_IDX_W = 8;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address stack for call/ret: push/pop of D-bit PCs with full/empty flags.
// Overflow/underflow policy lives in the caller; requests against full/empty are dropped here.
module pc_ret_stack #(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [D-1:0] i_data,
    output logic [D-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]  r_sp;
    logic [D-1:0]     r_mem [DEPTH];
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic [SP_W-1:0]  w_sp_dec;

    assign w_sp_dec = r_sp - 1'b1;
    assign w_wr_idx = r_sp[IDX_W-1:0];
    assign w_rd_idx = w_sp_dec[IDX_W-1:0];
    assign o_full   = (r_sp == SP_W'(DEPTH));
    assign o_empty  = (r_sp == '0);
    assign o_top    = r_mem[w_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (i_clr) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_sp <= w_sp_dec;
        end
    end

    // Storage needs no reset: only entries below the stack pointer are ever read.
    always_ff @(posedge clk) begin
        if (i_push && !o_full && !i_clr) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, IDLE/RUN/DONE control, jump-LUT branch resolution and saturating cycle count.
// Optional return stack for call/ret is enabled by defining PC_CALL_STACK_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          D           = 12,
    parameter int unsigned START_PC    = 0,
    parameter int          CYC_W       = 16,
    parameter int          STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 stall,
    input  logic                 branch_en,
    input  logic                 branch_taken,
    input  logic                 call_en,
    input  logic                 ret_en,
    input  logic [LUT_IDX_W-1:0] lut_idx,
    output logic [LUT_IDX_W-1:0] lut_addr,
    input  logic [D-1:0]         lut_target,
    output logic [D-1:0]         pc,
    output logic                 running,
    output logic                 done,
    output logic [CYC_W-1:0]     cycles,
    output logic                 stack_err
);

    pc_state_t        r_state, r_state_next;
    logic [D-1:0]     r_pc, r_pc_next;
    logic [CYC_W-1:0] r_cycles, r_cycles_next;
    logic             r_stack_err, r_stack_err_next;

    logic [D-1:0]     w_pc_inc;
    logic [CYC_W-1:0] w_cyc_inc;
    logic             w_push, w_pop, w_clr;
    logic             w_full, w_empty;
    logic [D-1:0]     w_top;

    assign lut_addr  = lut_idx;
    assign w_pc_inc  = r_pc + 1'b1;
    assign w_cyc_inc = (r_cycles == '1) ? r_cycles : r_cycles + 1'b1;

`ifdef PC_CALL_STACK_EN
    pc_ret_stack #(
        .D     (D),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
`else
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{call_en, ret_en, w_push, w_pop, w_clr};
    assign w_full  = 1'b0;
    assign w_empty = 1'b1;
    assign w_top   = '0;
`endif

    always_comb begin
        r_state_next     = r_state;
        r_pc_next        = r_pc;
        r_cycles_next    = r_cycles;
        r_stack_err_next = r_stack_err;
        w_push           = 1'b0;
        w_pop            = 1'b0;
        w_clr            = 1'b0;
        case (r_state)
            RUN: begin
                r_cycles_next = w_cyc_inc;
                if (halt) begin
                    r_state_next = DONE;
                end else if (stall) begin
                    r_pc_next = r_pc;
`ifdef PC_CALL_STACK_EN
                end else if (ret_en) begin
                    if (w_empty) begin
                        r_stack_err_next = 1'b1;
                        r_pc_next        = w_pc_inc;
                    end else begin
                        w_pop     = 1'b1;
                        r_pc_next = w_top;
                    end
                end else if (call_en) begin
                    // The jump is taken even when the return address cannot be saved.
                    r_pc_next = lut_target;
                    if (w_full) r_stack_err_next = 1'b1;
                    else        w_push = 1'b1;
`endif
                end else if (branch_en && branch_taken) begin
                    r_pc_next = lut_target;
                end else begin
                    r_pc_next = w_pc_inc;
                end
            end
            default: begin
                if (start) begin
                    r_state_next     = RUN;
                    r_pc_next        = D'(START_PC);
                    r_cycles_next    = '0;
                    r_stack_err_next = 1'b0;
                    w_clr            = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_cycles    <= '0;
            r_stack_err <= 1'b0;
        end else begin
            r_state     <= r_state_next;
            r_pc        <= r_pc_next;
            r_cycles    <= r_cycles_next;
            r_stack_err <= r_stack_err_next;
        end
    end

    assign pc        = r_pc;
    assign cycles    = r_cycles;
    assign running   = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign stack_err = r_stack_err;

endmodule
